oh_delay_train: RTL and testbench

Training controller for a tapped delay line. It sweeps the line's tap select, compares the delayed data against a known training pattern at each tap, then programs the tap to the centre of the widest contiguous passing window. It sits directly upstream of the delay element and drives its tap code; the delayed, sampled data returns on `din`.

---
 rtl/oh_delay_train.sv | 182 ++++++++++++++++++
 tb/tb_oh_delay_train.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/oh_delay_train.sv
`default_nettype none
// ============================================================================
//  Module   : oh_delay_train
//  Brief    : Sweeps a delay-line tap code, scores each tap against a training
//             pattern and parks the tap at the centre of the widest pass window.
//  Revision : 1.0 - initial release
// ============================================================================
module oh_delay_train #(
    parameter int DW     = 8,
    parameter int TW     = 5,
    parameter int SETTLE = 4,
    parameter int WINDOW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] pattern,
    output logic [TW-1:0] tap,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [TW-1:0] win_lo,
    output logic [TW-1:0] win_hi
);

    localparam int c_maxcnt = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int c_cw     = $clog2(c_maxcnt + 1);

    localparam logic [c_cw-1:0] c_settle_end = c_cw'(SETTLE - 1);
    localparam logic [c_cw-1:0] c_sample_end = c_cw'(WINDOW - 1);
    localparam logic [TW-1:0]   c_last_tap   = '1;
    localparam logic [TW:0]     c_len_one    = (TW+1)'(1);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_settle = 3'd1;
    localparam logic [2:0] c_sample = 3'd2;
    localparam logic [2:0] c_eval   = 3'd3;
    localparam logic [2:0] c_done   = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [c_cw-1:0] r_cnt;
    logic [TW-1:0]   r_tap;
    logic            r_pass;
    logic            r_open;
    logic [TW-1:0]   r_run_lo;
    logic [TW:0]     r_best_len;
    logic [TW-1:0]   r_best_lo;
    logic [TW-1:0]   r_best_hi;
    logic [TW-1:0]   r_win_lo;
    logic [TW-1:0]   r_win_hi;

    logic            w_last_tap;
    logic            w_close;
    logic [TW-1:0]   w_close_lo;
    logic [TW-1:0]   w_close_hi;
    logic [TW:0]     w_close_len;
    logic [TW:0]     w_nbest_len;
    logic [TW-1:0]   w_nbest_lo;
    logic [TW-1:0]   w_nbest_hi;
    logic [TW:0]     w_sum;
    logic [TW-1:0]   w_center;

    assign w_last_tap = (r_tap == c_last_tap);

    // A run closes either on the first failing tap after a pass, or at the top tap
    always_comb begin
        w_close    = 1'b0;
        w_close_lo = r_run_lo;
        w_close_hi = r_tap - TW'(1);
        if (r_pass && w_last_tap) begin
            w_close    = 1'b1;
            w_close_lo = r_open ? r_run_lo : r_tap;
            w_close_hi = r_tap;
        end else if (!r_pass && r_open) begin
            w_close = 1'b1;
        end
        w_close_len = {1'b0, w_close_hi} - {1'b0, w_close_lo} + c_len_one;
        w_nbest_len = r_best_len;
        w_nbest_lo  = r_best_lo;
        w_nbest_hi  = r_best_hi;
        if (w_close && (w_close_len > r_best_len)) begin
            w_nbest_len = w_close_len;
            w_nbest_lo  = w_close_lo;
            w_nbest_hi  = w_close_hi;
        end
    end

    assign w_sum    = {1'b0, r_win_lo} + {1'b0, r_win_hi};
    assign w_center = TW'(w_sum >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle, c_done: if (start) w_next = c_settle;
            c_settle:       if (r_cnt == c_settle_end) w_next = c_sample;
            c_sample:       if (r_cnt == c_sample_end) w_next = c_eval;
            c_eval:         w_next = w_last_tap ? c_done : c_settle;
            default:        w_next = c_idle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        fail = 1'b0;
        tap  = r_tap;
        case (r_state)
            c_settle, c_sample, c_eval: busy = 1'b1;
            c_done: begin
                done = 1'b1;
                fail = (r_best_len == '0);
                tap  = w_center;
            end
            default: ;
        endcase
    end

    assign win_lo = r_win_lo;
    assign win_hi = r_win_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_tap      <= '0;
            r_pass     <= 1'b0;
            r_open     <= 1'b0;
            r_run_lo   <= '0;
            r_best_len <= '0;
            r_best_lo  <= '0;
            r_best_hi  <= '0;
            r_win_lo   <= '0;
            r_win_hi   <= '0;
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (start) begin
                        r_cnt      <= '0;
                        r_tap      <= '0;
                        r_open     <= 1'b0;
                        r_best_len <= '0;
                        r_best_lo  <= '0;
                        r_best_hi  <= '0;
                    end
                end
                c_settle: begin
                    r_pass <= 1'b1;
                    r_cnt  <= (r_cnt == c_settle_end) ? '0 : r_cnt + c_cw'(1);
                end
                c_sample: begin
                    if (din != pattern) r_pass <= 1'b0;
                    r_cnt <= (r_cnt == c_sample_end) ? '0 : r_cnt + c_cw'(1);
                end
                c_eval: begin
                    r_best_len <= w_nbest_len;
                    r_best_lo  <= w_nbest_lo;
                    r_best_hi  <= w_nbest_hi;
                    r_open     <= r_pass && !w_last_tap;
                    if (r_pass && !r_open) r_run_lo <= r_tap;
                    if (w_last_tap) begin
                        r_win_lo <= (w_nbest_len != '0) ? w_nbest_lo : '0;
                        r_win_hi <= (w_nbest_len != '0) ? w_nbest_hi : '0;
                    end else begin
                        r_tap <= r_tap + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oh_delay_train.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oh_delay_train
//  Brief    : Directed sweeps against a mask-driven delay-line model; results
//             are queued at start and checked when done rises.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oh_delay_train;

    localparam int DW     = 8;
    localparam int TW     = 5;
    localparam int SETTLE = 4;
    localparam int WINDOW = 64;
    localparam int NTAPS  = 32;
    localparam int PER    = SETTLE + WINDOW + 1;
    localparam int LAT    = NTAPS * PER + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] din;
    logic [DW-1:0] pattern;
    logic [TW-1:0] tap;
    logic          busy;
    logic          done;
    logic          fail;
    logic [TW-1:0] win_lo;
    logic [TW-1:0] win_hi;

    logic [31:0]   mask;
    logic          glitch;

    typedef struct {
        int    lo;
        int    hi;
        int    tp;
        int    fl;
        string name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   t0    = 0;
    int   prev_lo = 0;
    int   prev_hi = 0;
    logic done_q  = 1'b0;

    oh_delay_train #(.DW(DW), .TW(TW), .SETTLE(SETTLE), .WINDOW(WINDOW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .din    (din),
        .pattern(pattern),
        .tap    (tap),
        .busy   (busy),
        .done   (done),
        .fail   (fail),
        .win_lo (win_lo),
        .win_hi (win_hi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Delay-line model: a passing tap returns the pattern, a failing tap corrupts it
    assign din = (mask[tap] && !glitch) ? pattern : (pattern ^ 8'h5a);

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done && !done_q) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                check({e.name, "_win_lo"}, int'(win_lo), e.lo);
                check({e.name, "_win_hi"}, int'(win_hi), e.hi);
                check({e.name, "_tap"}, int'(tap), e.tp);
                check({e.name, "_fail"}, int'(fail), e.fl);
                check({e.name, "_busy"}, int'(busy), 0);
                check({e.name, "_latency"}, cyc - t0 + 1, LAT);
            end
        end
        done_q <= done;
    end

    task automatic issue_start(input string nm);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        check({nm, "_c1_busy"}, int'(busy), 1);
        check({nm, "_c1_done"}, int'(done), 0);
        check({nm, "_c1_tap"}, int'(tap), 0);
        check({nm, "_c1_hold_lo"}, int'(win_lo), prev_lo);
        check({nm, "_c1_hold_hi"}, int'(win_hi), prev_hi);
    endtask

    task automatic sweep(input string nm, input logic [31:0] m, input logic [DW-1:0] p,
                         input int lo, input int hi, input int tp, input int fl,
                         input int gtap, input bit mid_pulse);
        exp_t e;
        int   target;
        bit   seen;
        mask    = m;
        pattern = p;
        e.lo = lo; e.hi = hi; e.tp = tp; e.fl = fl; e.name = nm;
        q.push_back(e);
        issue_start(nm);
        if (gtap >= 0) begin
            target = t0 + gtap * PER + SETTLE + WINDOW - 1;
            for (int i = 0; i < LAT && cyc != target; i++) @(negedge clk);
            glitch = 1'b1;
            @(negedge clk);
            glitch = 1'b0;
        end
        if (mid_pulse) begin
            repeat (1000) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < LAT + 50 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) check({nm, "_timeout"}, 0, 1);
        @(negedge clk);
        prev_lo = lo;
        prev_hi = hi;
    endtask

    initial begin
        bit hit;
        reset = 1'b1; start = 1'b0; glitch = 1'b0; mask = '0; pattern = '0;
        repeat (3) @(negedge clk);
        check("rst_tap", int'(tap), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_win_lo", int'(win_lo), 0);
        check("rst_win_hi", int'(win_hi), 0);
        reset = 1'b0;

        sweep("all_pass",  32'hFFFF_FFFF, 8'hA5, 0,  31, 15, 0, -1, 1'b0);
        sweep("mid_10_20", 32'h001F_FC00, 8'h3C, 10, 20, 15, 0, -1, 1'b0);
        sweep("two_win",   32'h1FF0_0078, 8'h81, 20, 28, 24, 0, -1, 1'b0);
        sweep("tie",       32'h0000_1C1C, 8'h0F, 2,  4,  3,  0, -1, 1'b0);
        sweep("top_win",   32'hFE00_0000, 8'hC3, 25, 31, 28, 0, -1, 1'b0);
        sweep("none",      32'h0000_0000, 8'h55, 0,  0,  0,  1, -1, 1'b0);
        sweep("glitch7",   32'h0000_03E0, 8'h96, 5,  6,  5,  0, 7,  1'b0);
        sweep("mid_start", 32'h001F_FC00, 8'h69, 10, 20, 15, 0, -1, 1'b1);

        // Aborted sweep: nothing queued, reset lands while tap 12 is selected
        mask = 32'h0000_0F00;
        pattern = 8'hE7;
        issue_start("abort");
        hit = 1'b0;
        for (int i = 0; i < LAT && !hit; i++) begin
            @(negedge clk);
            hit = (tap == 5'd12);
        end
        if (!hit) check("abort_reach_tap12", 0, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_tap", int'(tap), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_fail", int'(fail), 0);
        check("async_rst_win_lo", int'(win_lo), 0);
        check("async_rst_win_hi", int'(win_hi), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prev_lo = 0;
        prev_hi = 0;
        repeat (3) @(negedge clk);
        check("post_rst_idle_busy", int'(busy), 0);

        sweep("after_rst", 32'hFFFF_FFFF, 8'h5A, 0, 31, 15, 0, -1, 1'b0);

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
